// File: rtl/mcif_rd_arb_pkg.sv
// ---------------------------------------------------------------------------
// mcif_rd_arb_pkg
//   Shared constants for the MCIF read-channel arbiter. These are the CNN-top
//   values the arbiter and its tag FIFO default to.
//   - CNN_LEN_W    : burst-length field width (log2 of the AXI burst length)
//   - CNN_DW       : response data width (MAX_DAT_DW * Tout)
//   - CNN_OT_DEPTH : maximum outstanding bursts (power of two)
//   - port_e       : read-port index (feature-data DMA = 0, weight DMA = 1)
//   - PD_*_LSB     : field offsets inside a request payload
//                    {len_m1, addr_hi[31:0], addr_lo[31:0]}
// ---------------------------------------------------------------------------
package mcif_rd_arb_pkg;

  localparam int LOG2_AXI_BURST_LEN = 8;
  localparam int MAX_DAT_DW         = 16;
  localparam int TOUT               = 16;

  localparam int CNN_LEN_W    = LOG2_AXI_BURST_LEN;
  localparam int CNN_DW       = MAX_DAT_DW * TOUT;
  localparam int CNN_OT_DEPTH = 16;

  typedef enum logic {
    PORT_DAT = 1'b0,
    PORT_WT  = 1'b1
  } port_e;

  localparam int PD_ADDR_LO_LSB = 0;
  localparam int PD_ADDR_HI_LSB = 32;
  localparam int PD_LEN_LSB     = 64;

endpackage

// File: rtl/mcif_rd_tag_fifo.sv
// ---------------------------------------------------------------------------
// mcif_rd_tag_fifo
//   Synchronous FIFO holding one {src, len_m1} tag per outstanding burst, in
//   the order the bursts were issued to MCIF. Push and pop in the same cycle
//   both take effect. A push while full or a pop while empty is ignored.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_wdata at the tail
//   i_wdata    : tag to store
//   i_pop      : discard the head entry
//   o_rdata    : head entry (valid while !o_empty)
//   o_full     : DEPTH entries stored
//   o_empty    : no entries stored
//   o_count    : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module mcif_rd_tag_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  // NOTE: storage is deliberately left out of reset; occupancy and pointers
  // decide what is valid, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: all state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on their own.
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/mcif_rd_arb.sv
// ---------------------------------------------------------------------------
// mcif_rd_arb
//   Two-port read-channel arbiter in front of MCIF. The feature-data DMA
//   (dat, port 0) and the weight DMA (wt, port 1) each see a private read
//   port. Requests are granted round-robin into a single registered stage
//   toward MCIF; each grant pushes {src, len_m1} into an in-order tag FIFO
//   whose head steers returning beats back to the issuing port.
// Ports
//   clk, rst_n                      : clock, asynchronous active-low reset
//   dat_req_* / wt_req_*            : per-port request (vld/rdy/pd)
//   mcif_req_*                      : registered request toward MCIF
//   mcif_resp_*                     : response beats from MCIF, in order
//   dat_resp_* / wt_resp_*          : per-port response handshake
//   resp_pd                         : response data, shared by both ports
//   resp_last                       : current beat ends its burst
//   busy                            : a request staged or a burst pending
//   err_orphan                      : sticky, beat arrived with no burst
//                                     pending
// ---------------------------------------------------------------------------
module mcif_rd_arb
  import mcif_rd_arb_pkg::*;
#(
  parameter int LEN_W    = CNN_LEN_W,
  parameter int PD_W     = LEN_W + 64,
  parameter int DW       = CNN_DW,
  parameter int OT_DEPTH = CNN_OT_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            dat_req_vld,
  output logic            dat_req_rdy,
  input  logic [PD_W-1:0] dat_req_pd,
  input  logic            wt_req_vld,
  output logic            wt_req_rdy,
  input  logic [PD_W-1:0] wt_req_pd,

  output logic            mcif_req_vld,
  input  logic            mcif_req_rdy,
  output logic [PD_W-1:0] mcif_req_pd,

  input  logic            mcif_resp_vld,
  output logic            mcif_resp_rdy,
  input  logic [DW-1:0]   mcif_resp_pd,

  output logic            dat_resp_vld,
  input  logic            dat_resp_rdy,
  output logic            wt_resp_vld,
  input  logic            wt_resp_rdy,
  output logic [DW-1:0]   resp_pd,
  output logic            resp_last,

  output logic            busy,
  output logic            err_orphan
);

  localparam int TAG_W = 1 + LEN_W;
  localparam int CNT_W = $clog2(OT_DEPTH) + 1;

  // Request stage and arbitration state
  logic              r_stg_vld;
  logic [PD_W-1:0]   r_stg_pd;
  port_e             r_last_grant;

  // Response state
  logic [LEN_W-1:0]  r_beat_cnt;
  logic              r_err_orphan;

  logic              w_stg_free;
  logic              w_can_acc;
  logic              w_dat_acc;
  logic              w_wt_acc;
  logic              w_acc;
  port_e             w_grant;
  logic [PD_W-1:0]   w_acc_pd;

  logic [TAG_W-1:0]  w_tag_in;
  logic [TAG_W-1:0]  w_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_cnt;
  port_e             w_head_src;
  logic [LEN_W-1:0]  w_head_len;
  logic              w_sel_rdy;
  logic              w_beat_fire;
  logic              w_pop;

  // -------------------------------------------------------------------------
  // Request side
  // -------------------------------------------------------------------------
  // The stage can reload in the same cycle MCIF takes its current content,
  // so back-pressure never inserts a bubble.
  assign w_stg_free = ~r_stg_vld | mcif_req_rdy;
  // A full tag FIFO blocks accepts even when a pop is happening this cycle.
  assign w_can_acc  = w_stg_free & ~w_fifo_full;

  // Each port's ready looks only at the other port's valid: a port loses
  // only when the other one is also requesting and this port won last time.
  assign dat_req_rdy = w_can_acc & ~(wt_req_vld  & (r_last_grant == PORT_DAT));
  assign wt_req_rdy  = w_can_acc & ~(dat_req_vld & (r_last_grant == PORT_WT));

  assign w_dat_acc = dat_req_vld & dat_req_rdy;
  assign w_wt_acc  = wt_req_vld  & wt_req_rdy;
  assign w_acc     = w_dat_acc | w_wt_acc;
  assign w_grant   = w_wt_acc ? PORT_WT : PORT_DAT;
  assign w_acc_pd  = w_wt_acc ? wt_req_pd : dat_req_pd;

  // The tag is pushed at accept time; the single in-order stage guarantees
  // MCIF sees requests in the same order as the FIFO.
  assign w_tag_in = {w_grant, w_acc_pd[PD_LEN_LSB +: LEN_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_vld    <= 1'b0;
      r_stg_pd     <= '0;
      r_last_grant <= PORT_WT;
    end else begin
      if (w_acc) begin
        r_stg_vld    <= 1'b1;
        r_stg_pd     <= w_acc_pd;
        r_last_grant <= w_grant;
      end else if (mcif_req_rdy) begin
        r_stg_vld    <= 1'b0;
      end
    end
  end

  assign mcif_req_vld = r_stg_vld;
  assign mcif_req_pd  = r_stg_pd;

  // -------------------------------------------------------------------------
  // Tag FIFO
  // -------------------------------------------------------------------------
  mcif_rd_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (OT_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_acc),
    .i_wdata (w_tag_in),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

  assign w_head_src = port_e'(w_head[TAG_W-1]);
  assign w_head_len = w_head[LEN_W-1:0];

  // -------------------------------------------------------------------------
  // Response side (fully combinational steering)
  // -------------------------------------------------------------------------
  assign w_sel_rdy = (w_head_src == PORT_WT) ? wt_resp_rdy : dat_resp_rdy;

  assign dat_resp_vld = mcif_resp_vld & ~w_fifo_empty & (w_head_src == PORT_DAT);
  assign wt_resp_vld  = mcif_resp_vld & ~w_fifo_empty & (w_head_src == PORT_WT);

  // With nothing pending a stray beat is swallowed so MCIF cannot stall.
  assign mcif_resp_rdy = w_fifo_empty ? mcif_resp_vld : w_sel_rdy;

  assign resp_pd   = mcif_resp_pd;
  assign resp_last = ~w_fifo_empty & (r_beat_cnt == w_head_len);

  assign w_beat_fire = mcif_resp_vld & ~w_fifo_empty & w_sel_rdy;
  assign w_pop       = w_beat_fire & resp_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt   <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_beat_fire) begin
        r_beat_cnt <= resp_last ? '0 : r_beat_cnt + LEN_W'(1);
      end
      if (mcif_resp_vld & w_fifo_empty) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

  assign err_orphan = r_err_orphan;
  assign busy       = r_stg_vld | (w_fifo_cnt != '0);

endmodule
